// File: rtl/signal_lamp_driver.sv
// Six-lamp driver for a two-direction signal: timed amber, all-red clearance, flashing-red fault.
// Build option: define FAULT_RECOVER_EN to leave FAULT after RECOVER_CYCLES consecutive legal-input cycles.
//
// state     | meaning
// ALL_RED   | both red, clearance counting up (saturating)
// A_GREEN   | A green, B red, held while A requests
// A_AMBER   | A amber, B red, fixed AMBER_CYCLES dwell
// B_GREEN   | B green, A red, held while B requests
// B_AMBER   | B amber, A red, fixed AMBER_CYCLES dwell
// FAULT     | both reds flash together, ambers/greens dark
module signal_lamp_driver #(
    parameter int CNT_W          = 32,
    parameter int AMBER_CYCLES   = 20000000,
    parameter int ALLRED_CYCLES  = 10000000,
    parameter int FLASH_CYCLES   = 5000000,
    parameter int RECOVER_CYCLES = 30000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic a_go,
    input  logic a_stop,
    input  logic b_go,
    input  logic b_stop,
    output logic a_red,
    output logic a_amber,
    output logic a_green,
    output logic b_red,
    output logic b_amber,
    output logic b_green,
    output logic fault
);

    typedef enum logic [2:0] {
        S_ALL_RED,
        S_A_GREEN,
        S_A_AMBER,
        S_B_GREEN,
        S_B_AMBER,
        S_FAULT
    } state_t;

    if (AMBER_CYCLES < 1 || ALLRED_CYCLES < 1 || FLASH_CYCLES < 1 || RECOVER_CYCLES < 1) begin : g_param_check
        $error("signal_lamp_driver: all cycle parameters must be >= 1");
    end

    localparam logic [CNT_W-1:0] ALLRED_MAX  = CNT_W'(ALLRED_CYCLES);
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYCLES - 1);
    localparam logic [CNT_W-1:0] AMBER_LAST  = CNT_W'(AMBER_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_CYCLES - 1);
    // Lamp vector order: {fault, a_red, a_amber, a_green, b_red, b_amber, b_green}
    localparam logic [6:0] LAMP_ALL_RED = 7'b0_100_100;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flash_q, flash_d;
    logic [6:0]       lamp_q, lamp_d;
    logic             req_a, req_b, illegal;

    assign req_a   = a_go & ~a_stop;
    assign req_b   = b_go & ~b_stop;
    assign illegal = (a_go & b_go) | (a_go & a_stop) | (b_go & b_stop);

`ifdef FAULT_RECOVER_EN
    localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(RECOVER_CYCLES - 1);
    logic [CNT_W-1:0] rec_q, rec_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rec_q <= '0;
        else          rec_q <= rec_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flash_d = flash_q;
`ifdef FAULT_RECOVER_EN
        rec_d   = rec_q;
`endif
        case (state_q)
            S_ALL_RED: begin
                if (cnt_q != ALLRED_MAX) cnt_d = cnt_q + 1'b1;
                // cnt_q counts completed cycles, so this edge closes cycle cnt_q+1
                if (cnt_q >= ALLRED_LAST && req_a) begin
                    state_d = S_A_GREEN;
                    cnt_d   = '0;
                end else if (cnt_q >= ALLRED_LAST && req_b) begin
                    state_d = S_B_GREEN;
                    cnt_d   = '0;
                end
            end
            S_A_GREEN: begin
                if (!req_a) begin
                    state_d = S_A_AMBER;
                    cnt_d   = '0;
                end
            end
            S_B_GREEN: begin
                if (!req_b) begin
                    state_d = S_B_AMBER;
                    cnt_d   = '0;
                end
            end
            S_A_AMBER, S_B_AMBER: begin
                if (cnt_q >= AMBER_LAST) begin
                    state_d = S_ALL_RED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FAULT: begin
                if (cnt_q >= FLASH_LAST) begin
                    cnt_d   = '0;
                    flash_d = ~flash_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`ifdef FAULT_RECOVER_EN
                if (illegal) begin
                    rec_d = '0;
                end else if (rec_q >= REC_LAST) begin
                    state_d = S_ALL_RED;
                    cnt_d   = '0;
                    rec_d   = '0;
                end else begin
                    rec_d = rec_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_ALL_RED;
                cnt_d   = '0;
            end
        endcase

        // Re-entering FAULT from FAULT would restart the flash phase, so only enter once
        if (illegal && state_q != S_FAULT) begin
            state_d = S_FAULT;
            cnt_d   = '0;
            flash_d = 1'b1;
`ifdef FAULT_RECOVER_EN
            rec_d   = '0;
`endif
        end
    end

    always_comb begin
        lamp_d = LAMP_ALL_RED;
        case (state_d)
            S_A_GREEN: lamp_d = 7'b0_001_100;
            S_A_AMBER: lamp_d = 7'b0_010_100;
            S_B_GREEN: lamp_d = 7'b0_100_001;
            S_B_AMBER: lamp_d = 7'b0_100_010;
            S_FAULT:   lamp_d = {1'b1, flash_d, 2'b00, flash_d, 2'b00};
            default:   lamp_d = LAMP_ALL_RED;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_ALL_RED;
            cnt_q   <= '0;
            flash_q <= 1'b0;
            lamp_q  <= LAMP_ALL_RED;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flash_q <= flash_d;
            lamp_q  <= lamp_d;
        end
    end

    assign {fault, a_red, a_amber, a_green, b_red, b_amber, b_green} = lamp_q;

endmodule

// File: doc/signal_lamp_driver.md
Name: signal_lamp_driver

Overview:
- Downstream of the two-direction signal controller. Consumes its Ago/Astop/Bgo/Bstop commands and drives six physical lamps (red/amber/green per direction).
- Inserts a timed amber interval whenever a green ends, and an all-red clearance before any green starts.
- Any illegal command combination forces a fail-safe flashing-red fault mode.

Parameters:
- CNT_W, 32: width of the dwell/flash counter.
- AMBER_CYCLES, 20000000: exact amber dwell in clk cycles (>=1).
- ALLRED_CYCLES, 10000000: minimum all-red clearance in clk cycles (>=1).
- FLASH_CYCLES, 5000000: half-period of fault flashing in clk cycles (>=1).
- RECOVER_CYCLES, 30000000: legal-input run needed to exit fault; used only with FAULT_RECOVER_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- a_go  in  1  direction A go command
- a_stop  in  1  direction A stop command
- b_go  in  1  direction B go command
- b_stop  in  1  direction B stop command
- a_red, a_amber, a_green  out  1 each  direction A lamps (registered)
- b_red, b_amber, b_green  out  1 each  direction B lamps (registered)
- fault  out  1  fail-safe mode active (registered)

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (reset_n).
- Reset: state ALL_RED, counter 0, a_red=b_red=1, all amber/green=0, fault=0. Assertion mid-operation takes effect immediately (no clk needed), from any state.
- Inputs are sampled on each rising edge. Lamps are a Moore decode of registered state: a lamp change appears one clk after the deciding input edge.
- Request decode: reqA = a_go & ~a_stop, reqB = b_go & ~b_stop. All-zero inputs are legal and mean no request.
- Illegal inputs: (a_go & b_go) | (a_go & a_stop) | (b_go & b_stop). Checked every cycle in every state, highest priority. Illegal -> FAULT on the next edge.
- States:
  - ALL_RED: both red. Counter increments each cycle, saturating at ALLRED_CYCLES. Once the counter has reached ALLRED_CYCLES (i.e. ALL_RED occupied >= ALLRED_CYCLES cycles): reqA -> A_GREEN, else reqB -> B_GREEN, else stay.
  - A_GREEN: a_green=1, b_red=1. Stays while reqA. On ~reqA -> A_AMBER, counter cleared.
  - A_AMBER: a_amber=1, b_red=1. Lasts exactly AMBER_CYCLES cycles regardless of inputs, then -> ALL_RED with counter cleared.
  - B_GREEN / B_AMBER: mirror of A_GREEN / A_AMBER.
  - FAULT: fault=1, all amber/green=0. a_red and b_red are driven equal and toggle every FLASH_CYCLES cycles, starting at 1 on entry. Sticky until reset_n (see optional feature).
- No green minimum: a green ends on the first edge its request is absent.
- Simultaneous events:
  - A request drops while B rises in the same cycle: -> A_AMBER. B is served only after amber plus full clearance.
  - Request reasserted during amber: ignored; amber completes, then clearance.
- Never both greens, and never a green together with the other direction's amber. Guaranteed by construction.
- Counter is CNT_W bits, unsigned, saturating; never wraps.

Optional Feature:
- Macro: FAULT_RECOVER_EN.
- Defined: in FAULT, a second counter counts consecutive legal-input cycles and is cleared on any illegal cycle. On reaching RECOVER_CYCLES: -> ALL_RED with counter 0, fault=0, full clearance enforced.
- Undefined: FAULT exits only via reset_n. No recovery counter is synthesised.

Test Plan (AMBER_CYCLES=4, ALLRED_CYCLES=3, FLASH_CYCLES=2, RECOVER_CYCLES=5):
1. Release reset_n with all inputs 0 -> a_red=b_red=1, all others 0, fault=0, held for 50 cycles.
2. a_go=1, b_stop=1 from reset release -> a_green=1 exactly 3 clks after release; b_red stays 1 throughout.
3. In A_GREEN, set a_go=0, a_stop=1, b_go=1, b_stop=0 on the same edge:
   - next clk: a_green=0, a_amber=1 for exactly 4 cycles;
   - then both red for exactly 3 cycles;
   - then b_green=1.
4. In B_GREEN, drive a_go=1 with b_go=1 for one cycle -> next clk: fault=1, greens/ambers 0; a_red=b_red pattern 1,1,0,0,1,1,... persisting after inputs return legal (feature off).
5. Assert reset_n=0 mid A_AMBER, between clock edges -> a_red=b_red=1 and a_amber=0 immediately, without a clk edge; after release, 3-cycle clearance precedes any green.
6. FAULT_RECOVER_EN defined: enter FAULT, then legal inputs for 4 cycles, 1 illegal, then legal for 5 -> fault clears only after the final 5-cycle run; both red then hold for 3 cycles before any green.
